// File: rtl/dma_copy_engine_pkg.sv
// Shared parameters and FSM encoding for the DMA copy engine and its word counter.
package dma_copy_engine_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_copy_engine_word_counter.sv
// Word counter for the DMA engine: holds cnt, flags the last word and forms the
// source/destination addresses (modulo 2^ADDR_W) for the value cnt takes next cycle.
module dma_word_counter
  import dma_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              last,
  output logic [ADDR_W-1:0] src_addr_next,
  output logic [ADDR_W-1:0] dst_addr_next
);

  localparam logic [ADDR_W:0] ONE = 1;

  logic [ADDR_W:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt is one bit wider than an address so len = 2^ADDR_W terminates correctly.
  assign last          = (cnt_q + ONE) == len;
  assign src_addr_next = src_base + cnt_d[ADDR_W-1:0];
  assign dst_addr_next = dst_base + cnt_d[ADDR_W-1:0];

endmodule

// File: rtl/dma_copy_engine.sv
// Word-granular DMA copy engine driving the shared data-memory port.
// Optional fill mode (constant pattern writes) is enabled by defining DMA_FILL_EN.
module dma_copy_engine
  import dma_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              mem_read_q, mem_read_d, mem_write_en_q, mem_write_en_d;
  logic [ADDR_W-1:0] mem_access_addr_q, mem_access_addr_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;

  logic              cnt_clr, cnt_inc, last;
  logic [ADDR_W-1:0] src_base, dst_base, src_next, dst_next;

  logic              start_fill, run_fill;
  logic [DATA_W-1:0] start_fill_value, run_fill_value;

`ifdef DMA_FILL_EN
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fill_value_q, fill_value_d;

  always_comb begin
    fill_d       = fill_q;
    fill_value_d = fill_value_q;
    if (state_q == IDLE && start) begin
      fill_d       = fill;
      fill_value_d = fill_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q       <= 1'b0;
      fill_value_q <= '0;
    end else begin
      fill_q       <= fill_d;
      fill_value_q <= fill_value_d;
    end
  end

  assign start_fill       = fill;
  assign start_fill_value = fill_value;
  assign run_fill         = fill_q;
  assign run_fill_value   = fill_value_q;
`else
  assign start_fill       = 1'b0;
  assign start_fill_value = '0;
  assign run_fill         = 1'b0;
  assign run_fill_value   = '0;
`endif

  dma_word_counter #(.ADDR_W(ADDR_W)) u_counter (
    .clk           (clk),
    .rst           (rst),
    .clr           (cnt_clr),
    .inc           (cnt_inc),
    .len           (len_q),
    .src_base      (src_base),
    .dst_base      (dst_base),
    .last          (last),
    .src_addr_next (src_next),
    .dst_addr_next (dst_next)
  );

  always_comb begin
    state_d           = state_q;
    src_d             = src_q;
    dst_d             = dst_q;
    len_d             = len_q;
    src_base          = src_q;
    dst_base          = dst_q;
    cnt_clr           = 1'b0;
    cnt_inc           = 1'b0;
    done_d            = 1'b0;
    mem_read_d        = 1'b0;
    mem_write_en_d    = 1'b0;
    mem_access_addr_d = '0;
    mem_write_data_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else begin
            src_d    = src_addr;
            dst_d    = dst_addr;
            len_d    = len;
            src_base = src_addr;
            dst_base = dst_addr;
            cnt_clr  = 1'b1;
            state_d  = start_fill ? WRITE : READ;
          end
        end
      end
      READ:  state_d = WRITE;
      WRITE: begin
        cnt_inc = 1'b1;
        if (last)          state_d = DONE;
        else if (run_fill) state_d = WRITE;
        else               state_d = READ;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode them from the state entered at this edge.
    unique case (state_d)
      READ: begin
        mem_read_d        = 1'b1;
        mem_access_addr_d = src_next;
      end
      WRITE: begin
        mem_write_en_d    = 1'b1;
        mem_access_addr_d = dst_next;
        if (state_q == READ)      mem_write_data_d = mem_read_data;
        else if (state_q == IDLE) mem_write_data_d = start_fill_value;
        else                      mem_write_data_d = run_fill_value;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      src_q             <= '0;
      dst_q             <= '0;
      len_q             <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_en_q    <= 1'b0;
      mem_access_addr_q <= '0;
      mem_write_data_q  <= '0;
    end else begin
      state_q           <= state_d;
      src_q             <= src_d;
      dst_q             <= dst_d;
      len_q             <= len_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      mem_read_q        <= mem_read_d;
      mem_write_en_q    <= mem_write_en_d;
      mem_access_addr_q <= mem_access_addr_d;
      mem_write_data_q  <= mem_write_data_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign mem_read        = mem_read_q;
  assign mem_write_en    = mem_write_en_q;
  assign mem_access_addr = mem_access_addr_q;
  assign mem_write_data  = mem_write_data_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: directed cases plus randomized copies
// compared against a word-array reference model of forward copying.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  src_addr, dst_addr;
  logic [8:0]  len;
  logic        busy, done, mem_write_en, mem_read;
  logic [7:0]  mem_access_addr;
  logic [31:0] mem_write_data, mem_read_data;
`ifdef DMA_FILL_EN
  logic        fill;
  logic [31:0] fill_value;
`endif

  always #5 clk = ~clk;

  dma_copy_engine dut (
    .clk             (clk),
    .rst             (rst),
`ifdef DMA_FILL_EN
    .fill            (fill),
    .fill_value      (fill_value),
`endif
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  // Data memory: combinational read, write on rising edge; bench preloads via pre_*.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  assign mem_read_data = mem[mem_access_addr];

  always @(posedge clk) begin
    if (pre_we)            mem[pre_addr] <= pre_data;
    else if (mem_write_en) mem[mem_access_addr] <= mem_write_data;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a[7:0];
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
    ref_mem[a % 256] = d;
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // One transaction; expected per-cycle port activity derives from the copy rules:
  // copy = alternating read src+i / write dst+i, fill = write dst+i every cycle.
  task automatic run_copy(input string tag, input int src, input int dst, input int n,
                          input bit use_fill, input logic [31:0] fv, input bit poke_mid);
    int exp_done, done_at, proto_errs, idx, wait_cyc;
    logic [43:0] got_v, exp_v;
    logic        e_rd, e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    exp_done   = use_fill ? n + 1 : 2 * n + 1;
    done_at    = -1;
    proto_errs = 0;
    @(negedge clk);
    start    = 1'b1;
    src_addr = src[7:0];
    dst_addr = dst[7:0];
    len      = n[8:0];
`ifdef DMA_FILL_EN
    fill       = use_fill;
    fill_value = fv;
`endif
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      e_rd = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (k < exp_done) begin
        if (use_fill) begin
          idx = k - 1;
          e_we = 1'b1; e_addr = 8'((dst + idx) % 256); e_wd = fv;
        end else if (k % 2 == 1) begin
          idx = (k - 1) / 2;
          e_rd = 1'b1; e_addr = 8'((src + idx) % 256);
        end else begin
          idx = k / 2 - 1;
          e_we = 1'b1; e_addr = 8'((dst + idx) % 256); e_wd = ref_mem[(src + idx) % 256];
        end
      end
      exp_v = {k <= exp_done, k == exp_done, e_rd, e_we, e_addr, e_wd};
      got_v = {busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data};
      if (got_v !== exp_v) proto_errs++;
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (e_we) ref_mem[e_addr] = e_wd;
      if (poke_mid && k == 3) begin
        start    = 1'b1;
        src_addr = 8'($urandom);
        dst_addr = 8'($urandom);
        len      = 9'd5;
      end
      if (poke_mid && k == 4) start = 1'b0;
    end
    start    = 1'b0;
    wait_cyc = 0;
    while (busy !== 1'b0 && wait_cyc < 1200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, "/done_cycle"}, 64'(done_at), 64'(exp_done));
    check({tag, "/port_activity"}, 64'(proto_errs), 64'd0);
    check({tag, "/memory"}, 64'(mem_diffs()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, n;
    bit f;
    rst      = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
`ifdef DMA_FILL_EN
    fill       = 1'b0;
    fill_value = '0;
`endif
    #1;
    check("reset/outputs", {busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle/outputs", {busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data}, 0);

    for (int i = 0; i < 256; i++) poke(i, $urandom);

    for (int i = 0; i < 4; i++) poke(10 + i, 32'(i + 1));
    run_copy("basic", 10, 40, 4, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) check("basic/dst_word", mem[40 + i], 64'(i + 1));

    run_copy("zero_len", 3, 7, 0, 1'b0, 0, 1'b0);

    poke(254, 32'hA);
    poke(255, 32'hB);
    poke(0, 32'hC);
    run_copy("wrap", 254, 100, 3, 1'b0, 0, 1'b0);
    check("wrap/m100", mem[100], 64'hA);
    check("wrap/m101", mem[101], 64'hB);
    check("wrap/m102", mem[102], 64'hC);

    poke(5, 32'd7);
    poke(6, 32'd8);
    run_copy("overlap", 5, 6, 2, 1'b0, 0, 1'b0);
    check("overlap/m6", mem[6], 64'd7);
    check("overlap/m7", mem[7], 64'd7);

    run_copy("start_while_busy", 30, 200, 6, 1'b0, 0, 1'b1);

    // Reset in the third cycle of an 8-word copy: only word 0 has been written.
    @(negedge clk);
    start    = 1'b1;
    src_addr = 8'd60;
    dst_addr = 8'd120;
    len      = 9'd8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("rst_mid/in_read", mem_read, 1);
    rst = 1'b1;
    #1;
    check("rst_mid/outputs", {busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data}, 0);
    ref_mem[120] = ref_mem[60];
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/memory", 64'(mem_diffs()), 64'd0);
    run_copy("after_rst", 60, 120, 8, 1'b0, 0, 1'b0);

`ifdef DMA_FILL_EN
    run_copy("fill", 0, 20, 5, 1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 5; i++) check("fill/dst_word", mem[20 + i], 64'hDEADBEEF);
`endif

    run_copy("full_mem", 17, 90, 256, 1'b0, 0, 1'b0);

    for (int it = 0; it < 16; it++) begin
      s = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 255));
      n = (it % 5 == 4) ? 0 : int'($urandom_range(1, 12));
      f = 1'b0;
`ifdef DMA_FILL_EN
      f = $urandom_range(0, 1) == 1;
`endif
      run_copy("random", s, d, n, f, $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
